// File: rtl/mem_pattern_tester_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_pattern_tester_if
// Description : Data-side memory port between the pattern tester (master)
//               and cpu_interface (slave). The master issues one registered
//               request at a time and holds it until mem_stall is low at a
//               rising edge.
// Ports       : dmem_read, dmem_write   - request strobes (master -> slave)
//               dmem_addr  [ADDR_W]     - word address
//               dmem_wdata [DATA_W]     - write data
//               dmem_byte_w_en          - byte enables, DATA_W/8 bits
//               dmem_rdata [DATA_W]     - read data (slave -> master)
//               mem_stall               - request not yet complete
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_pattern_tester_if #(
    parameter int ADDR_W = 30,
    parameter int DATA_W = 32
);
    logic                  dmem_read;
    logic                  dmem_write;
    logic [ADDR_W-1:0]     dmem_addr;
    logic [DATA_W-1:0]     dmem_wdata;
    logic [DATA_W/8-1:0]   dmem_byte_w_en;
    logic [DATA_W-1:0]     dmem_rdata;
    logic                  mem_stall;

    modport master (
        output dmem_read,
        output dmem_write,
        output dmem_addr,
        output dmem_wdata,
        output dmem_byte_w_en,
        input  dmem_rdata,
        input  mem_stall
    );

    modport slave (
        input  dmem_read,
        input  dmem_write,
        input  dmem_addr,
        input  dmem_wdata,
        input  dmem_byte_w_en,
        output dmem_rdata,
        output mem_stall
    );
endinterface
`default_nettype wire

// File: rtl/mem_pattern_tester.sv
`default_nettype none
// ============================================================================
// Module      : mem_pattern_tester
// Description : Memory traffic generator/checker. Each pass writes NUM_WORDS
//               pattern words, reads them back, compares and accumulates
//               error statistics. Passes run on a start pulse or repeat every
//               INTERVAL idle cycles while auto_run is high.
// Ports       : ui_clk          - memory-interface user clock
//               rst             - asynchronous reset, active low
//               start           - one-cycle pulse, starts a pass when idle
//               auto_run        - level, repeat passes every INTERVAL cycles
//               mode[1:0]       - 0 walking one, 1 address, 2 ~address,
//                                 3 LFSR (or walking one when not built)
//               dmem            - memory port (master modport)
//               busy, done      - pass in progress / end-of-pass pulse
//               pass_cnt        - completed passes (wraps)
//               err_cnt         - mismatching words (saturates)
//               first_err_addr  - address of first mismatch since reset
//               err_flag        - sticky mismatch flag
//               led[7:0]        - low byte of last word read
// Options     : define MEM_TEST_LFSR_EN to build the mode-3 pseudo-random
//               pattern generator.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_pattern_tester #(
    parameter int                ADDR_W      = 30,
    parameter int                DATA_W      = 32,
    parameter int                NUM_WORDS   = 8,
    parameter logic [ADDR_W-1:0] ADDR_BASE   = 'h1000,
    parameter int                ADDR_STRIDE = 1,
    parameter int                PASS_STRIDE = 32,
    parameter int                INTERVAL    = 50000000
) (
    input  wire logic              ui_clk,
    input  wire logic              rst,
    input  wire logic              start,
    input  wire logic              auto_run,
    input  wire logic [1:0]        mode,
    mem_pattern_tester_if.master   dmem,
    output logic                   busy,
    output logic                   done,
    output logic [15:0]            pass_cnt,
    output logic [15:0]            err_cnt,
    output logic [ADDR_W-1:0]      first_err_addr,
    output logic                   err_flag,
    output logic [7:0]             led
);

    localparam int c_IW   = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int c_CW   = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
    localparam int c_SH   = $clog2(DATA_W);
    localparam int c_WIDE = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int c_BE   = DATA_W / 8;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WAIT  = 3'd1,
        S_WRITE = 3'd2,
        S_READ  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_nx;

    logic [c_IW-1:0]     r_idx;
    logic [c_CW-1:0]     r_interval;
    logic [ADDR_W-1:0]   r_base;
    logic [ADDR_W-1:0]   r_addr;
    logic [1:0]          r_mode;
    logic [DATA_W-1:0]   r_walk;
    logic [DATA_W-1:0]   r_expect;
    logic [DATA_W-1:0]   r_wdata;
    logic [c_BE-1:0]     r_ben;
    logic                r_read;
    logic                r_write;
    logic [15:0]         r_pass_cnt;
    logic [15:0]         r_err_cnt;
    logic [ADDR_W-1:0]   r_first_err_addr;
    logic                r_err_flag;
    logic [7:0]          r_led;

    logic                w_xfer;
    logic                w_last;
    logic [ADDR_W-1:0]   w_nx_addr;
    logic [DATA_W-1:0]   w_nx_walk;
    logic [DATA_W-1:0]   w_seed_walk;
    logic [DATA_W-1:0]   w_nx_rnd;
    logic [DATA_W-1:0]   w_seed_rnd;
    logic [DATA_W-1:0]   w_nx_pat;
    logic [DATA_W-1:0]   w_start_pat;
    logic [DATA_W-1:0]   w_reload_pat;

    // Pattern for one word. rnd is the LFSR word when that option is built,
    // otherwise the walking-one word, which makes mode 3 alias mode 0.
    function automatic logic [DATA_W-1:0] f_pattern(
        input logic [1:0]        m,
        input logic [ADDR_W-1:0] a,
        input logic [DATA_W-1:0] walk,
        input logic [DATA_W-1:0] rnd
    );
        logic [c_WIDE-1:0] wide;
        wide = c_WIDE'(a);
        case (m)
            2'd0:    return walk;
            2'd1:    return wide[DATA_W-1:0];
            2'd2:    return ~wide[DATA_W-1:0];
            default: return rnd;
        endcase
    endfunction

    assign w_xfer    = (r_read | r_write) & ~dmem.mem_stall;
    assign w_last    = (r_idx == c_IW'(NUM_WORDS - 1));
    assign w_nx_addr = r_addr + ADDR_W'(ADDR_STRIDE);
    assign w_nx_walk = {r_walk[DATA_W-2:0], r_walk[DATA_W-1]};

    // Walking one starts at bit (pass_cnt mod DATA_W); rotating by one per
    // word then yields bit (i + pass_cnt) mod DATA_W without an adder.
    assign w_seed_walk = {{(DATA_W-1){1'b0}}, 1'b1} << r_pass_cnt[c_SH-1:0];

`ifdef MEM_TEST_LFSR_EN
    localparam logic [31:0] c_LFSR_SEED = 32'hACE1_0000;
    // Galois form of x^32 + x^22 + x^2 + x + 1, shifting right.
    localparam logic [31:0] c_LFSR_TAPS = 32'h8020_0003;

    logic [31:0] r_lfsr;
    logic [31:0] w_seed_lfsr;

    function automatic logic [31:0] f_lfsr_step(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ c_LFSR_TAPS) : (s >> 1);
    endfunction

    // Narrow buses take the low bits; wide buses repeat the 32-bit word.
    function automatic logic [DATA_W-1:0] f_widen(input logic [31:0] v);
        logic [DATA_W-1:0] d;
        for (int k = 0; k < DATA_W; k++) begin
            d[k] = v[k % 32];
        end
        return d;
    endfunction

    assign w_seed_lfsr = c_LFSR_SEED ^ {16'h0000, r_pass_cnt};
    assign w_nx_rnd    = f_widen(f_lfsr_step(r_lfsr));
    assign w_seed_rnd  = f_widen(w_seed_lfsr);

    // Seeded identically at the start of the write and read phases so the
    // read-back expectation replays the written sequence.
    always_ff @(posedge ui_clk or negedge rst) begin
        if (!rst) begin
            r_lfsr <= '0;
        end else begin
            if ((r_state == S_IDLE || r_state == S_WAIT) && w_state_nx == S_WRITE) begin
                r_lfsr <= w_seed_lfsr;
            end else if (r_state == S_WRITE && w_xfer && w_last) begin
                r_lfsr <= w_seed_lfsr;
            end else if ((r_state == S_WRITE || r_state == S_READ) && w_xfer) begin
                r_lfsr <= f_lfsr_step(r_lfsr);
            end
        end
    end
`else
    assign w_nx_rnd   = w_nx_walk;
    assign w_seed_rnd = w_seed_walk;
`endif

    // The first word of a pass uses the live mode input (it is captured on
    // that same edge); every later word uses the captured copy.
    assign w_nx_pat     = f_pattern(r_mode, w_nx_addr, w_nx_walk, w_nx_rnd);
    assign w_start_pat  = f_pattern(mode,   r_base,    w_seed_walk, w_seed_rnd);
    assign w_reload_pat = f_pattern(r_mode, r_base,    w_seed_walk, w_seed_rnd);

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge ui_clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nx = S_WRITE;
                end else if (auto_run) begin
                    w_state_nx = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!auto_run) begin
                    w_state_nx = S_IDLE;
                end else if (r_interval == c_CW'(INTERVAL - 1)) begin
                    w_state_nx = S_WRITE;
                end
            end
            S_WRITE: begin
                if (w_xfer && w_last) begin
                    w_state_nx = S_READ;
                end
            end
            S_READ: begin
                if (w_xfer && w_last) begin
                    w_state_nx = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nx = auto_run ? S_WAIT : S_IDLE;
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    // ----------------------------------------------------------- datapath
    always_ff @(posedge ui_clk or negedge rst) begin
        if (!rst) begin
            r_idx            <= '0;
            r_interval       <= '0;
            r_base           <= ADDR_BASE;
            r_addr           <= '0;
            r_mode           <= '0;
            r_walk           <= '0;
            r_expect         <= '0;
            r_wdata          <= '0;
            r_ben            <= '0;
            r_read           <= 1'b0;
            r_write          <= 1'b0;
            r_pass_cnt       <= '0;
            r_err_cnt        <= '0;
            r_first_err_addr <= '0;
            r_err_flag       <= 1'b0;
            r_led            <= '0;
        end else begin
            r_interval <= (r_state == S_WAIT) ? r_interval + c_CW'(1) : '0;

            case (r_state)
                S_IDLE, S_WAIT: begin
                    if (w_state_nx == S_WRITE) begin
                        r_mode   <= mode;
                        r_idx    <= '0;
                        r_addr   <= r_base;
                        r_walk   <= w_seed_walk;
                        r_expect <= w_start_pat;
                        r_wdata  <= w_start_pat;
                        r_ben    <= '1;
                        r_write  <= 1'b1;
                    end
                end
                S_WRITE: begin
                    if (w_xfer) begin
                        if (w_last) begin
                            r_idx    <= '0;
                            r_addr   <= r_base;
                            r_walk   <= w_seed_walk;
                            r_expect <= w_reload_pat;
                            r_wdata  <= '0;
                            r_ben    <= '0;
                            r_write  <= 1'b0;
                            r_read   <= 1'b1;
                        end else begin
                            r_idx    <= r_idx + c_IW'(1);
                            r_addr   <= w_nx_addr;
                            r_walk   <= w_nx_walk;
                            r_expect <= w_nx_pat;
                            r_wdata  <= w_nx_pat;
                        end
                    end
                end
                S_READ: begin
                    if (w_xfer) begin
                        r_led <= dmem.dmem_rdata[7:0];
                        if (dmem.dmem_rdata != r_expect) begin
                            if (r_err_cnt != 16'hFFFF) begin
                                r_err_cnt <= r_err_cnt + 16'd1;
                            end
                            r_err_flag <= 1'b1;
                            if (!r_err_flag) begin
                                r_first_err_addr <= r_addr;
                            end
                        end
                        if (w_last) begin
                            r_idx  <= '0;
                            r_read <= 1'b0;
                        end else begin
                            r_idx    <= r_idx + c_IW'(1);
                            r_addr   <= w_nx_addr;
                            r_walk   <= w_nx_walk;
                            r_expect <= w_nx_pat;
                        end
                    end
                end
                S_DONE: begin
                    r_pass_cnt <= r_pass_cnt + 16'd1;
                    r_base     <= r_base + ADDR_W'(PASS_STRIDE);
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------ outputs
    assign dmem.dmem_read      = r_read;
    assign dmem.dmem_write     = r_write;
    assign dmem.dmem_addr      = r_addr;
    assign dmem.dmem_wdata     = r_wdata;
    assign dmem.dmem_byte_w_en = r_ben;

    assign busy           = (r_state == S_WRITE) || (r_state == S_READ) || (r_state == S_DONE);
    assign done           = (r_state == S_DONE);
    assign pass_cnt       = r_pass_cnt;
    assign err_cnt        = r_err_cnt;
    assign first_err_addr = r_first_err_addr;
    assign err_flag       = r_err_flag;
    assign led            = r_led;

endmodule
`default_nettype wire

// File: tb/tb_mem_pattern_tester.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_pattern_tester
// Description : Directed self-checking bench for mem_pattern_tester with a
//               behavioural memory that can stall each request and corrupt
//               the word at address 0x1003.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_pattern_tester;

    logic        ui_clk;
    logic        rst;
    logic        start;
    logic        auto_run;
    logic [1:0]  mode;
    logic        busy;
    logic        done;
    logic [15:0] pass_cnt;
    logic [15:0] err_cnt;
    logic [29:0] first_err_addr;
    logic        err_flag;
    logic [7:0]  led;

    int n_tests = 0;
    int n_fail  = 0;

    // memory model controls, driven from the stimulus block
    int   n_stall  = 0;
    logic fault_en = 1'b0;

    mem_pattern_tester_if #(.ADDR_W(30), .DATA_W(32)) bus ();

    mem_pattern_tester #(
        .ADDR_W      (30),
        .DATA_W      (32),
        .NUM_WORDS   (8),
        .ADDR_BASE   (30'h1000),
        .ADDR_STRIDE (1),
        .PASS_STRIDE (32),
        .INTERVAL    (10)
    ) dut (
        .ui_clk         (ui_clk),
        .rst            (rst),
        .start          (start),
        .auto_run       (auto_run),
        .mode           (mode),
        .dmem           (bus),
        .busy           (busy),
        .done           (done),
        .pass_cnt       (pass_cnt),
        .err_cnt        (err_cnt),
        .first_err_addr (first_err_addr),
        .err_flag       (err_flag),
        .led            (led)
    );

    initial ui_clk = 1'b0;
    always #5 ui_clk = ~ui_clk;

    // ---------------------------------------------------------- memory model
    logic [31:0] mem [0:255];
    logic [29:0] wlog_addr [0:511];
    logic [31:0] wlog_data [0:511];
    int          wlog_n     = 0;
    int          stall_ctr  = 0;
    int          req_cycles = 0;
    int          reads      = 0;
    int          both_hi    = 0;
    int          unstable   = 0;
    int          ben_bad    = 0;
    int          done_cnt   = 0;
    logic        prev_stall = 1'b0;
    logic [29:0] prev_addr  = '0;
    logic [31:0] prev_wdata = '0;
    logic        w_req;

    assign w_req          = bus.dmem_read | bus.dmem_write;
    assign bus.mem_stall  = w_req && (stall_ctr < n_stall);
    // The fault flips bit 0: on the odd address 0x1003 a stuck-high bit would
    // be invisible under the address-as-data pattern.
    assign bus.dmem_rdata = mem[bus.dmem_addr[7:0]]
                          ^ ((fault_en && bus.dmem_addr == 30'h1003) ? 32'h1 : 32'h0);

    always @(posedge ui_clk) begin
        if (done) done_cnt <= done_cnt + 1;
        if (bus.dmem_read && bus.dmem_write) both_hi <= both_hi + 1;
        if (prev_stall && (!w_req || bus.dmem_addr != prev_addr || bus.dmem_wdata != prev_wdata))
            unstable <= unstable + 1;
        prev_stall <= bus.mem_stall;
        prev_addr  <= bus.dmem_addr;
        prev_wdata <= bus.dmem_wdata;
        if (!rst) begin
            stall_ctr <= 0;
        end else if (w_req) begin
            req_cycles <= req_cycles + 1;
            if (bus.mem_stall) begin
                stall_ctr <= stall_ctr + 1;
            end else begin
                stall_ctr <= 0;
                if (bus.dmem_write) begin
                    mem[bus.dmem_addr[7:0]] <= bus.dmem_wdata;
                    wlog_addr[wlog_n % 512] <= bus.dmem_addr;
                    wlog_data[wlog_n % 512] <= bus.dmem_wdata;
                    wlog_n <= wlog_n + 1;
                    if (bus.dmem_byte_w_en != 4'hF) ben_bad <= ben_bad + 1;
                end else begin
                    reads <= reads + 1;
                    if (bus.dmem_byte_w_en != 4'h0) ben_bad <= ben_bad + 1;
                end
            end
        end
    end

    // ---------------------------------------------------------------- tasks
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Counts clock edges from the caller's negedge until done is seen.
    task automatic wait_done(input string tag, output int cycles);
        cycles = 0;
        do begin
            @(negedge ui_clk);
            start = 1'b0;
            cycles++;
        end while (!done && cycles < 500);
        chk(tag, {31'd0, done}, 32'd1);
    endtask

    task automatic do_reset();
        rst      = 1'b0;
        start    = 1'b0;
        auto_run = 1'b0;
        n_stall  = 0;
        fault_en = 1'b0;
        repeat (2) @(negedge ui_clk);
        rst = 1'b1;
        @(negedge ui_clk);
    endtask

    // --------------------------------------------------------------- stimulus
    initial begin
        int c, s, r0, rq0, d0;
        rst      = 1'b0;
        start    = 1'b0;
        auto_run = 1'b0;
        mode     = 2'd0;
        repeat (3) @(negedge ui_clk);

        // reset state
        chk("rst_busy",  {31'd0, busy}, 32'd0);
        chk("rst_done",  {31'd0, done}, 32'd0);
        chk("rst_req",   {30'd0, bus.dmem_read, bus.dmem_write}, 32'd0);
        chk("rst_cnts",  {pass_cnt, err_cnt}, 32'd0);
        chk("rst_ferr",  {2'd0, first_err_addr}, 32'd0);
        chk("rst_flag_led", {23'd0, err_flag, led}, 32'd0);
        chk("rst_ben",   {28'd0, bus.dmem_byte_w_en}, 32'd0);
        rst = 1'b1;
        @(negedge ui_clk);

        // single pass, no stalls, walking one
        s = wlog_n; r0 = reads; rq0 = req_cycles; d0 = done_cnt;
        start = 1'b1;
        wait_done("t1_done", c);
        chk("t1_cycles", c, 32'd17);
        @(negedge ui_clk);
        chk("t1_nwrites", wlog_n - s, 32'd8);
        for (int i = 0; i < 8; i++) begin
            chk("t1_waddr", {2'd0, wlog_addr[(s + i) % 512]}, 32'h1000 + i);
            chk("t1_wdata", wlog_data[(s + i) % 512], 32'd1 << i);
        end
        chk("t1_reads",   reads - r0, 32'd8);
        chk("t1_reqcyc",  req_cycles - rq0, 32'd16);
        chk("t1_dones",   done_cnt - d0, 32'd1);
        chk("t1_errcnt",  {16'd0, err_cnt}, 32'd0);
        chk("t1_led",     {24'd0, led}, 32'h80);
        chk("t1_passcnt", {16'd0, pass_cnt}, 32'd1);
        chk("t1_idle",    {31'd0, busy}, 32'd0);

        // same pass with three stall cycles per request
        do_reset();
        n_stall = 3;
        s = wlog_n; r0 = reads; rq0 = req_cycles; d0 = unstable;
        start = 1'b1;
        wait_done("t2_done", c);
        chk("t2_cycles", c, 32'd65);
        @(negedge ui_clk);
        chk("t2_nwrites", wlog_n - s, 32'd8);
        for (int i = 0; i < 8; i++) begin
            chk("t2_waddr", {2'd0, wlog_addr[(s + i) % 512]}, 32'h1000 + i);
            chk("t2_wdata", wlog_data[(s + i) % 512], 32'd1 << i);
        end
        chk("t2_reads",   reads - r0, 32'd8);
        chk("t2_reqcyc",  req_cycles - rq0, 32'd64);
        chk("t2_stable",  unstable - d0, 32'd0);
        chk("t2_errcnt",  {16'd0, err_cnt}, 32'd0);
        chk("t2_led",     {24'd0, led}, 32'h80);
        chk("t2_passcnt", {16'd0, pass_cnt}, 32'd1);

        // corrupted word at 0x1003, address-as-data
        do_reset();
        fault_en = 1'b1;
        mode = 2'd1;
        start = 1'b1;
        wait_done("t3_done", c);
        @(negedge ui_clk);
        chk("t3_errcnt", {16'd0, err_cnt}, 32'd1);
        chk("t3_flag",   {31'd0, err_flag}, 32'd1);
        chk("t3_ferr",   {2'd0, first_err_addr}, 32'h1003);
        chk("t3_led",    {24'd0, led}, 32'h07);
        // second pass, inverted address, base moved by PASS_STRIDE
        mode = 2'd2;
        s = wlog_n;
        start = 1'b1;
        wait_done("t3b_done", c);
        @(negedge ui_clk);
        chk("t3b_waddr",  {2'd0, wlog_addr[s % 512]}, 32'h1020);
        chk("t3b_wdata",  wlog_data[s % 512], 32'hFFFF_EFDF);
        chk("t3b_errcnt", {16'd0, err_cnt}, 32'd1);
        chk("t3b_ferr",   {2'd0, first_err_addr}, 32'h1003);
        chk("t3b_led",    {24'd0, led}, 32'hD8);
        chk("t3b_passcnt", {16'd0, pass_cnt}, 32'd2);

        // asynchronous reset in the middle of the read phase
        fault_en = 1'b0;
        mode = 2'd0;
        start = 1'b1;
        repeat (12) begin
            @(negedge ui_clk);
            start = 1'b0;
        end
        chk("t4_inread", {31'd0, bus.dmem_read}, 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("t4_rd_drop", {30'd0, bus.dmem_read, bus.dmem_write}, 32'd0);
        chk("t4_cnts",    {pass_cnt, err_cnt}, 32'd0);
        chk("t4_flag",    {31'd0, err_flag}, 32'd0);
        chk("t4_ferr",    {2'd0, first_err_addr}, 32'd0);
        chk("t4_busy",    {31'd0, busy}, 32'd0);
        @(negedge ui_clk);
        rst = 1'b1;
        @(negedge ui_clk);
        s = wlog_n;
        start = 1'b1;
        wait_done("t4b_done", c);
        chk("t4b_cycles", c, 32'd17);
        chk("t4b_waddr",  {2'd0, wlog_addr[s % 512]}, 32'h1000);
        chk("t4b_wdata",  wlog_data[s % 512], 32'h01);
        @(negedge ui_clk);
        chk("t4b_errcnt", {16'd0, err_cnt}, 32'd0);

        // auto mode, INTERVAL = 10
        do_reset();
        mode = 2'd0;
        auto_run = 1'b1;
        wait_done("t5_done1", c);
        chk("t5_first", c, 32'd27);
        s = wlog_n;
        wait_done("t5_done2", c);
        chk("t5_spacing", c, 32'd27);
        chk("t5_waddr", {2'd0, wlog_addr[s % 512]}, 32'h1020);
        chk("t5_wdata", wlog_data[s % 512], 32'h02);
        repeat (15) @(negedge ui_clk);
        chk("t5_midpass", {31'd0, busy}, 32'd1);
        auto_run = 1'b0;
        wait_done("t5_done3", c);
        chk("t5_finish", c, 32'd12);
        rq0 = req_cycles;
        repeat (30) @(negedge ui_clk);
        chk("t5_idle",    {31'd0, busy}, 32'd0);
        chk("t5_noreq",   req_cycles - rq0, 32'd0);
        chk("t5_passcnt", {16'd0, pass_cnt}, 32'd3);

        // mode 3
        do_reset();
        mode = 2'd3;
        s = wlog_n;
        start = 1'b1;
        wait_done("t6_done", c);
        @(negedge ui_clk);
`ifdef MEM_TEST_LFSR_EN
        chk("t6_lfsr0", wlog_data[s % 512], 32'hACE1_0000);
        chk("t6_lfsr1", wlog_data[(s + 1) % 512], 32'h5670_8000);
`else
        for (int i = 0; i < 8; i++) begin
            chk("t6_wdata", wlog_data[(s + i) % 512], 32'd1 << i);
        end
`endif
        chk("t6_errcnt", {16'd0, err_cnt}, 32'd0);

        // protocol-wide checks
        chk("rd_wr_excl", both_hi, 32'd0);
        chk("byte_en",    ben_bad, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
